kpyd_scan_ctrl: RTL

- Matrix-keypad scan controller: drives one keypad row at a time, samples the column lines, and debounces every key per frame.
- Emits one key-code event per debounced press on a valid/ready output.
- Sits between the keypad pins and the keypad decode/consumer logic.
- Provides the sequencing and per-key debounce/edge function for the whole matrix, so no per-key edge machines run free.

---
 rtl/kpyd_pkg.sv | 21 ++
 rtl/kpyd_key_debounce.sv | 64 ++++++
 rtl/kpyd_scan_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/kpyd_pkg.sv
// kpyd_pkg: shared types and helpers for the keypad scan controller.
//   state_e         - scan FSM states (eIdle, eSettle, eSample)
//   kpyd_key_w()    - key-code width, clog2(rows*cols) with a minimum of 1
//   kpyd_frame_len()- cycles needed to scan every row once
package kpyd_pkg;

  typedef enum logic [1:0] {
    eIdle   = 2'd0,
    eSettle = 2'd1,
    eSample = 2'd2
  } state_e;

  function automatic int kpyd_key_w(input int rows, input int cols);
    return ($clog2(rows * cols) < 1) ? 1 : $clog2(rows * cols);
  endfunction

  function automatic int kpyd_frame_len(input int rows, input int settle);
    return rows * (settle + 1);
  endfunction

endpackage

// File: rtl/kpyd_key_debounce.sv
// kpyd_key_debounce: debounce state for one key.
// Ports:
//   clk_i, reset_i   - clock, asynchronous active-low reset
//   sample_i         - high during the sample cycle of this key's row
//   raw_i            - sampled key level, 1 = pressed
//   commit_i         - accept this key's pending change this cycle
//   stable_o         - debounced state, 1 = pressed
//   cand_o           - change candidate: the key has differed from its stable
//                      state for debounce_samples_p consecutive samples
module kpyd_key_debounce #(
  parameter int debounce_samples_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sample_i,
  input  logic raw_i,
  input  logic commit_i,
  output logic stable_o,
  output logic cand_o
);

  localparam int CntW = $clog2(debounce_samples_p + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(debounce_samples_p);

  if (debounce_samples_p < 1) begin : g_samples_chk
    $error("debounce_samples_p must be >= 1");
  end

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_inc  = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
    // The candidate is judged on the count this sample would produce, so the
    // change can commit in the same sample that reaches the threshold.
    cand_o   = sample_i && (raw_i != stable_q) && (cnt_inc == CntMax);
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sample_i) begin
      if (commit_i && cand_o) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else if (raw_i == stable_q) begin
        cnt_d = '0;
      end else begin
        // An uncommitted candidate stays saturated and retries next frame.
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/kpyd_scan_ctrl.sv
// kpyd_scan_ctrl: matrix keypad scanner with per-key debounce and a one-deep
// valid/ready key-event output.
// Ports:
//   clk_i, reset_i   - clock, asynchronous active-low reset
//   enable_i         - scan enable, sampled when a row sample completes
//   col_i            - raw column pins, active-low, asynchronous
//   row_o            - row drive, active-low one-hot, all ones = idle
//   key_v_o          - key event valid
//   key_ready_i      - consumer ready
//   key_o            - key code = row*cols_p + col
//   pressed_o        - debounced state per key, 1 = pressed
//   key_release_o    - 1 = release event (only with KPYD_RELEASE_EVT_EN)
// Build option: define KPYD_RELEASE_EVT_EN to emit release events through the
// same output path; otherwise releases update pressed_o silently.
module kpyd_scan_ctrl
  import kpyd_pkg::*;
#(
  parameter  int rows_p             = 4,
  parameter  int cols_p             = 4,
  parameter  int settle_cycles_p    = 8,
  parameter  int debounce_samples_p = 4,
  localparam int KeysN              = rows_p * cols_p,
  localparam int KeyW               = kpyd_key_w(rows_p, cols_p)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [cols_p-1:0] col_i,
  output logic [rows_p-1:0] row_o,
  output logic              key_v_o,
  input  logic              key_ready_i,
  output logic [KeyW-1:0]   key_o,
  output logic [KeysN-1:0]  pressed_o
`ifdef KPYD_RELEASE_EVT_EN
  ,
  output logic              key_release_o
`endif
);

  localparam int RowW = (rows_p > 1) ? $clog2(rows_p) : 1;
  localparam int SetW = $clog2(settle_cycles_p);

  // Two synchronizer cycles must fit inside the settle window.
  if (settle_cycles_p < 3) begin : g_settle_chk
    $error("settle_cycles_p must be >= 3");
  end

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [SetW-1:0]   set_cnt_q, set_cnt_d;
  logic [cols_p-1:0] col_s1_q, col_s2_q;

  logic [KeysN-1:0]  cand, stable, commit, sample_en;
  logic              evt;
  logic [KeyW-1:0]   evt_code;
  logic              out_free;
  logic              key_v_q, key_v_d;
  logic [KeyW-1:0]   key_q, key_d;
`ifdef KPYD_RELEASE_EVT_EN
  logic              evt_rel;
  logic              rel_q, rel_d;
`endif

  // Scan sequencing
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    set_cnt_d = set_cnt_q;
    case (state_q)
      eIdle: begin
        row_d     = '0;
        set_cnt_d = '0;
        if (enable_i) state_d = eSettle;
      end
      eSettle: begin
        if (set_cnt_q == SetW'(settle_cycles_p - 1)) begin
          state_d   = eSample;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      eSample: begin
        set_cnt_d = '0;
        if (enable_i) begin
          state_d = eSettle;
          row_d   = (row_q == RowW'(rows_p - 1)) ? '0 : row_q + 1'b1;
        end else begin
          state_d = eIdle;
          row_d   = '0;
        end
      end
      default: begin
        state_d = eIdle;
        row_d   = '0;
      end
    endcase
  end

  always_comb begin
    row_o = '1;
    if (state_q != eIdle) row_o[row_q] = 1'b0;
  end

  // Per-key debounce; only the keys of the driven row see a sample pulse.
  for (genvar r = 0; r < rows_p; r++) begin : g_row
    for (genvar c = 0; c < cols_p; c++) begin : g_col
      assign sample_en[r*cols_p+c] = (state_q == eSample) && (row_q == RowW'(r));
      kpyd_key_debounce #(
        .debounce_samples_p(debounce_samples_p)
      ) u_key (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sample_i(sample_en[r*cols_p+c]),
        .raw_i   (~col_s2_q[c]),
        .commit_i(commit[r*cols_p+c]),
        .stable_o(stable[r*cols_p+c]),
        .cand_o  (cand[r*cols_p+c])
      );
    end
  end

  // Candidates only exist in the current row, so ascending key index is
  // lowest column first.
  always_comb begin
    commit   = '0;
    evt      = 1'b0;
    evt_code = '0;
`ifdef KPYD_RELEASE_EVT_EN
    evt_rel  = 1'b0;
`endif
    out_free = ~key_v_q | key_ready_i;
    for (int k = 0; k < KeysN; k++) begin
      if (cand[k]) begin
`ifdef KPYD_RELEASE_EVT_EN
        if (!evt && out_free) begin
          commit[k] = 1'b1;
          evt       = 1'b1;
          evt_code  = KeyW'(k);
          evt_rel   = stable[k];
        end
`else
        if (stable[k]) begin
          commit[k] = 1'b1;
        end else if (!evt && out_free) begin
          commit[k] = 1'b1;
          evt       = 1'b1;
          evt_code  = KeyW'(k);
        end
`endif
      end
    end
  end

  // Output register: a commit in a transfer cycle reloads without a bubble.
  always_comb begin
    key_v_d = key_v_q;
    key_d   = key_q;
`ifdef KPYD_RELEASE_EVT_EN
    rel_d   = rel_q;
`endif
    if (evt) begin
      key_v_d = 1'b1;
      key_d   = evt_code;
`ifdef KPYD_RELEASE_EVT_EN
      rel_d   = evt_rel;
`endif
    end else if (key_v_q && key_ready_i) begin
      key_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= eIdle;
      row_q     <= '0;
      set_cnt_q <= '0;
      col_s1_q  <= '1;
      col_s2_q  <= '1;
      key_v_q   <= 1'b0;
      key_q     <= '0;
`ifdef KPYD_RELEASE_EVT_EN
      rel_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      set_cnt_q <= set_cnt_d;
      col_s1_q  <= col_i;
      col_s2_q  <= col_s1_q;
      key_v_q   <= key_v_d;
      key_q     <= key_d;
`ifdef KPYD_RELEASE_EVT_EN
      rel_q     <= rel_d;
`endif
    end
  end

  assign key_v_o   = key_v_q;
  assign key_o     = key_q;
  assign pressed_o = stable;
`ifdef KPYD_RELEASE_EVT_EN
  assign key_release_o = rel_q;
`endif

endmodule
